// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register scoreboard busy bit and a
// saturating accepted-write counter.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports (rbusyN reads 0 while forwarding). Without it the read
// ports return the stored value and stored busy bit.
//
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   raddr1/2            - read addresses
//   rdata1/2            - combinational read data (0 for r0 when ZERO_R0,
//                         and for addresses >= READ_LIMIT)
//   rbusy1/2            - scoreboard busy bit of the read address
//   we, waddr, wdata    - write port
//   rsv_en, rsv_addr    - mark a destination register pending (busy)
//   wr_count            - saturating count of accepted writes
module regfile_sb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int READ_LIMIT = 24,
  parameter int ZERO_R0    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy1,
  output logic              rbusy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [15:0]       wr_count
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam logic [31:0] RLIM  = READ_LIMIT;

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic              wr_acc;
  logic              rsv_ok;
  logic              forced1;
  logic              forced2;

  // A read is forced to zero above the read limit or for the hardwired r0.
  function automatic logic read_forced(input logic [ADDR_W-1:0] a);
    return (32'(a) >= RLIM) || ((ZERO_R0 != 0) && (a == '0));
  endfunction

  assign wr_acc  = we && !((ZERO_R0 != 0) && (waddr == '0));
  assign rsv_ok  = rsv_en && !((ZERO_R0 != 0) && (rsv_addr == '0));
  assign forced1 = read_forced(raddr1);
  assign forced2 = read_forced(raddr2);

  // Reservation is applied after the write clear so it wins on a collision.
  always_comb begin
    busy_nxt = busy;
    if (wr_acc) busy_nxt[waddr] = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
      busy     <= '0;
      wr_count <= '0;
    end else begin
      if (wr_acc) begin
        mem[waddr] <= wdata;
        if (wr_count != '1) wr_count <= wr_count + 16'd1;
      end
      busy <= busy_nxt;
    end
  end

  always_comb begin
    rdata1 = forced1 ? '0 : mem[raddr1];
    rdata2 = forced2 ? '0 : mem[raddr2];
    rbusy1 = forced1 ? 1'b0 : busy[raddr1];
    rbusy2 = forced2 ? 1'b0 : busy[raddr2];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so the outputs stay at zero.
    if (!rst && we && !forced1 && (waddr == raddr1)) begin
      rdata1 = wdata;
      rbusy1 = 1'b0;
    end
    if (!rst && we && !forced2 && (waddr == raddr2)) begin
      rdata2 = wdata;
      rbusy2 = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  raddr1, raddr2, waddr, rsv_addr;
  logic [31:0] rdata1, rdata2, wdata;
  logic        rbusy1, rbusy2, we, rsv_en;
  logic [15:0] wr_count;

  int checks   = 0;
  int failures = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .READ_LIMIT(24), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .rbusy1(rbusy1), .rbusy2(rbusy2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0; waddr = 5'd0; wdata = '0;
    rsv_addr = 5'd0; we = 1'b1; rsv_en = 1'b1;
    tick();
    raddr1 = 5'd5; raddr2 = 5'd6; waddr = 5'd5; wdata = 32'h1234; rsv_addr = 5'd6;
    #1;
    checks++; if (rdata1 !== 32'd0) begin failures++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
    checks++; if (rbusy2 !== 1'b0) begin failures++; $display("FAIL reset_rbusy2 got=%b exp=0", rbusy2); end
    checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    idle();
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd14; wdata = 32'hDEADBEEF; raddr1 = 5'd14;
    #1;
    checks++; if (rdata1 !== (BYP ? 32'hDEADBEEF : 32'd0)) begin failures++; $display("FAIL pre_edge_rdata1 got=%h exp=%h", rdata1, BYP ? 32'hDEADBEEF : 32'd0); end
    tick(); idle();
    checks++; if (rdata1 !== 32'hDEADBEEF) begin failures++; $display("FAIL write_r14 got=%h exp=deadbeef", rdata1); end
    checks++; if (wr_count !== 16'd1) begin failures++; $display("FAIL count_after_r14 got=%0d exp=1", wr_count); end
    we = 1'b1; waddr = 5'd0; wdata = 32'd7; raddr1 = 5'd0;
    tick(); idle();
    checks++; if (rdata1 !== 32'd0) begin failures++; $display("FAIL r0_read got=%h exp=0", rdata1); end
    checks++; if (wr_count !== 16'd1) begin failures++; $display("FAIL r0_not_counted got=%0d exp=1", wr_count); end
  endtask

  task automatic test_read_limit();
    we = 1'b1; waddr = 5'd25; wdata = 32'd9; raddr2 = 5'd25;
    rsv_en = 1'b1; rsv_addr = 5'd25;
    tick(); idle();
    checks++; if (rdata2 !== 32'd0) begin failures++; $display("FAIL r25_rdata2 got=%h exp=0", rdata2); end
    checks++; if (rbusy2 !== 1'b0) begin failures++; $display("FAIL r25_rbusy2 got=%b exp=0", rbusy2); end
    checks++; if (wr_count !== 16'd2) begin failures++; $display("FAIL r25_counted got=%0d exp=2", wr_count); end
    we = 1'b1; waddr = 5'd23; wdata = 32'h23; raddr2 = 5'd23;
    tick(); idle();
    checks++; if (rdata2 !== 32'h23) begin failures++; $display("FAIL r23_boundary got=%h exp=23", rdata2); end
    checks++; if (wr_count !== 16'd3) begin failures++; $display("FAIL r23_counted got=%0d exp=3", wr_count); end
  endtask

  task automatic test_reserve();
    rsv_en = 1'b1; rsv_addr = 5'd3; raddr1 = 5'd3; raddr2 = 5'd3;
    tick(); idle();
    checks++; if (rbusy1 !== 1'b1) begin failures++; $display("FAIL rsv_r3_busy got=%b exp=1", rbusy1); end
    checks++; if (rbusy2 !== 1'b1) begin failures++; $display("FAIL rsv_r3_busy2 got=%b exp=1", rbusy2); end
    rsv_en = 1'b1; rsv_addr = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 32'd4;
    tick(); idle();
    checks++; if (rbusy1 !== 1'b1) begin failures++; $display("FAIL rsv_wins got=%b exp=1", rbusy1); end
    checks++; if (rdata1 !== 32'd4) begin failures++; $display("FAIL rsv_write_data got=%h exp=4", rdata1); end
    checks++; if (wr_count !== 16'd4) begin failures++; $display("FAIL rsv_write_count got=%0d exp=4", wr_count); end
    we = 1'b1; waddr = 5'd3; wdata = 32'd5;
    tick(); idle();
    checks++; if (rbusy1 !== 1'b0) begin failures++; $display("FAIL write_clears_busy got=%b exp=0", rbusy1); end
    checks++; if (rdata1 !== 32'd5) begin failures++; $display("FAIL r3_second_write got=%h exp=5", rdata1); end
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick(); idle();
    raddr2 = 5'd9;
    #1;
    checks++; if (rbusy2 !== 1'b1) begin failures++; $display("FAIL rsv_r9_busy got=%b exp=1", rbusy2); end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'h11; rsv_en = 1'b1; rsv_addr = 5'd7;
    tick(); idle();
    we = 1'b1; waddr = 5'd7; wdata = 32'h55; raddr1 = 5'd7;
    #1;
    checks++; if (rdata1 !== (BYP ? 32'h55 : 32'h11)) begin failures++; $display("FAIL same_cycle_rdata1 got=%h exp=%h", rdata1, BYP ? 32'h55 : 32'h11); end
    checks++; if (rbusy1 !== (BYP ? 1'b0 : 1'b1)) begin failures++; $display("FAIL same_cycle_rbusy1 got=%b exp=%b", rbusy1, BYP ? 1'b0 : 1'b1); end
    tick(); idle();
    checks++; if (rdata1 !== 32'h55) begin failures++; $display("FAIL r7_after_edge got=%h exp=55", rdata1); end
    checks++; if (rbusy1 !== 1'b0) begin failures++; $display("FAIL r7_busy_cleared got=%b exp=0", rbusy1); end
    checks++; if (wr_count !== 16'd7) begin failures++; $display("FAIL r7_count got=%0d exp=7", wr_count); end
  endtask

  task automatic test_reset_mid();
    we = 1'b1; waddr = 5'd14; wdata = 32'd5; raddr1 = 5'd14; raddr2 = 5'd9;
    tick(); idle();
    checks++; if (rdata1 !== 32'd5) begin failures++; $display("FAIL r14_before_reset got=%h exp=5", rdata1); end
    checks++; if (wr_count !== 16'd8) begin failures++; $display("FAIL count_before_reset got=%0d exp=8", wr_count); end
    #2;
    we = 1'b1; waddr = 5'd14; wdata = 32'd77; rsv_en = 1'b1; rsv_addr = 5'd14;
    rst = 1'b1;
    #1;
    checks++; if (rdata1 !== 32'd0) begin failures++; $display("FAIL async_reset_rdata1 got=%h exp=0", rdata1); end
    checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", wr_count); end
    checks++; if (rbusy2 !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", rbusy2); end
    checks++; if (rbusy1 !== 1'b0) begin failures++; $display("FAIL reset_rsv_ignored got=%b exp=0", rbusy1); end
    tick();
    idle();
    #1 rst = 1'b0;
    tick();
    checks++; if (rdata1 !== 32'd0) begin failures++; $display("FAIL no_partial_write got=%h exp=0", rdata1); end
    checks++; if (rbusy1 !== 1'b0) begin failures++; $display("FAIL no_partial_rsv got=%b exp=0", rbusy1); end
  endtask

  task automatic test_saturate();
    raddr1 = 5'd1;
    we = 1'b1; waddr = 5'd1;
    for (int i = 0; i < 65540; i++) begin
      wdata = i;
      tick();
    end
    checks++; if (wr_count !== 16'hFFFF) begin failures++; $display("FAIL saturate got=%h exp=ffff", wr_count); end
    for (int i = 0; i < 3; i++) begin
      wdata = 32'hA0 + i;
      tick();
    end
    idle();
    checks++; if (wr_count !== 16'hFFFF) begin failures++; $display("FAIL saturate_hold got=%h exp=ffff", wr_count); end
    checks++; if (rdata1 !== 32'hA2) begin failures++; $display("FAIL saturate_data got=%h exp=a2", rdata1); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_limit();
    test_reserve();
    test_bypass();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5: register address width; depth NREGS = 2**ADDR_W.
REQ-003 SHALL provide parameter READ_LIMIT, default 24: addresses >= READ_LIMIT read as zero.
REQ-004 SHALL provide parameter ZERO_R0, default 1: when 1, register 0 reads 0 and ignores writes.
REQ-005 SHALL provide port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL provide port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL provide ports raddr1/raddr2, input, ADDR_W: read addresses, ports 1 and 2.
REQ-008 SHALL provide ports rdata1/rdata2, output, DATA_W: combinational read data.
REQ-009 SHALL provide ports rbusy1/rbusy2, output, 1: scoreboard busy bit of raddr1/raddr2.
REQ-010 SHALL provide ports we (input, 1), waddr (input, ADDR_W) and wdata (input, DATA_W): write port.
REQ-011 SHALL provide ports rsv_en (input, 1) and rsv_addr (input, ADDR_W): mark a destination pending.
REQ-012 SHALL provide port wr_count, output, 16: saturating count of accepted writes.

Function
REQ-013 SHALL write wdata to waddr at the rising edge when we=1, except waddr=0 with ZERO_R0=1, which is dropped and not counted.
REQ-014 SHALL store writes to addresses >= READ_LIMIT, but rdataN for such addresses SHALL be 0.
REQ-015 SHALL drive rdataN = mem[raddrN] combinationally, forced to 0 for raddrN >= READ_LIMIT or (raddrN=0 and ZERO_R0=1).
REQ-016 SHALL set busy[rsv_addr] at the rising edge when rsv_en=1; rsv_addr=0 with ZERO_R0=1 is ignored.
REQ-017 SHALL clear busy[waddr] at the rising edge of every accepted write.
REQ-018 SHALL keep busy set when rsv_en and an accepted write target the same address in one cycle (reserve wins); data is still written.
REQ-019 SHALL drive rbusyN = busy[raddrN] combinationally; it is 0 wherever rdataN is forced to 0.
REQ-020 SHALL increment wr_count by 1 per accepted write, holding at 16'hFFFF (no wrap).
REQ-021 SHALL give write-to-read latency of 1 cycle when bypass is disabled (new value visible after the edge).

Reset
REQ-022 SHALL, while rst=1 and independent of clk, clear all registers, all busy bits and wr_count to 0.
REQ-023 SHALL, while rst=1, drive rdata1/2=0, rbusy1/2=0 and wr_count=0, ignoring we and rsv_en.
REQ-024 SHALL abandon any write or reservation coincident with reset assertion, leaving no partial update.

Configuration
REQ-025 SHALL, with macro REGFILE_BYPASS_EN defined, drive rdataN = wdata and rbusyN = 0 when we=1, waddr=raddrN and the read is not forced to 0 (same-cycle forwarding).
REQ-026 SHALL, without REGFILE_BYPASS_EN, return the stored value and stored busy bit in the write cycle, with no comparator logic.

Verification
REQ-027 SHALL cover: assert rst mid-run after writing 5 to r14 -> rdata1(raddr1=14)=0, wr_count=0 immediately, before any clk edge.
REQ-028 SHALL cover: write 0xDEADBEEF to r14, read raddr1=14 next cycle -> rdata1=0xDEADBEEF, wr_count=1; write r0=7 -> rdata=0, wr_count unchanged.
REQ-029 SHALL cover: write 9 to r25 -> rdata2(raddr2=25)=0 and rbusy2=0; no error, wr_count increments.
REQ-030 SHALL cover: rsv r3, then rsv_en+we to r3 with wdata=4 in one cycle -> rbusy1=1, rdata1=4 after edge; next plain write to r3 -> rbusy1=0.
REQ-031 SHALL cover: same-cycle we r7=0x55, raddr1=7 -> rdata1=0x55 combinationally with REGFILE_BYPASS_EN; old value without it.
REQ-032 SHALL cover: 65540 consecutive writes -> wr_count=16'hFFFF, unchanged by further writes.
